// File: rtl/stone_renderer.sv
// Scans the stone table on each frame start, erasing stale sprites and drawing new or moved ones
// as a one-pixel-per-cycle plot stream; a shadow copy of each entry suppresses redundant redraws.
module stone_renderer #(
  parameter int         STONE_SIZE   = 16,
  parameter int         READ_LATENCY = 2,
  parameter int         SCREEN_W     = 320,
  parameter int         SCREEN_H     = 240,
  parameter logic [2:0] BG_COLOUR    = 3'b000,
  parameter logic [2:0] C_STONE      = 3'b111,
  parameter logic [2:0] C_GOLD       = 3'b110,
  parameter logic [2:0] C_DIAMOND    = 3'b011
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        full_redraw,
  input  logic [3:0]  quantity,
  output logic [3:0]  rd_address,
  input  logic [31:0] rd_data,
  output logic [8:0]  plot_x,
  output logic [7:0]  plot_y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam int          CW    = (STONE_SIZE > 1) ? $clog2(STONE_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(STONE_SIZE - 1);
  localparam logic [9:0]  SCR_W = 10'(SCREEN_W);
  localparam logic [8:0]  SCR_H = 9'(SCREEN_H);
  localparam logic [1:0]  LAT   = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_WAIT, S_DECODE, S_ERASE, S_DRAW, S_NEXT, S_DONE
  } state_t;

  state_t        state;
  logic [3:0]    idx;
  logic [3:0]    q_lat;
  logic          fr_lat;
  logic [1:0]    wait_cnt;
  logic [8:0]    cur_x;
  logic [7:0]    cur_y;
  logic [1:0]    cur_type;
  logic          cur_vis;
  logic [CW-1:0] dx;
  logic [CW-1:0] dy;

  logic [8:0]    sh_x   [16];
  logic [7:0]    sh_y   [16];
  logic          sh_vis [16];

  logic          moved;
  logic          need_erase;
  logic          need_draw;
  logic          erasing;
  logic [8:0]    base_x;
  logic [7:0]    base_y;
  logic [9:0]    sum_x;
  logic [8:0]    sum_y;
  logic          in_range;
  logic [2:0]    type_colour;
  logic [2:0]    pix_colour;
  logic          box_last;
  logic          unused_rd;

  assign unused_rd = ^{rd_data[22:19], rd_data[10:4], rd_data[0]};

  always_comb begin
    moved      = (cur_x != sh_x[idx]) || (cur_y != sh_y[idx]);
    need_erase = sh_vis[idx] && (!cur_vis || moved);
    need_draw  = cur_vis && (fr_lat || !sh_vis[idx] || moved);
  end

  // Erase rasters the shadowed box, draw rasters the freshly read one.
  always_comb begin
    erasing  = (state == S_ERASE);
    base_x   = erasing ? sh_x[idx] : cur_x;
    base_y   = erasing ? sh_y[idx] : cur_y;
    sum_x    = {1'b0, base_x} + 10'(dx);
    sum_y    = {1'b0, base_y} + 9'(dy);
    in_range = (sum_x < SCR_W) && (sum_y < SCR_H);
    case (cur_type)
      2'b00:   type_colour = C_STONE;
      2'b01:   type_colour = C_GOLD;
      default: type_colour = C_DIAMOND;
    endcase
    pix_colour = erasing ? BG_COLOUR : type_colour;
    box_last   = (dx == LAST) && (dy == LAST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      idx        <= '0;
      q_lat      <= '0;
      fr_lat     <= 1'b0;
      wait_cnt   <= '0;
      cur_x      <= '0;
      cur_y      <= '0;
      cur_type   <= '0;
      cur_vis    <= 1'b0;
      dx         <= '0;
      dy         <= '0;
      rd_address <= '0;
      plot_x     <= '0;
      plot_y     <= '0;
      colour     <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        sh_x[i]   <= '0;
        sh_y[i]   <= '0;
        sh_vis[i] <= 1'b0;
      end
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          idx <= '0;
          // done is still high on the cycle right after a scan, so a start there is dropped
          if (start && !done) begin
            fr_lat <= full_redraw;
            q_lat  <= quantity;
            busy   <= 1'b1;
            state  <= (quantity == 4'd0) ? S_DONE : S_ADDR;
          end
        end
        S_ADDR: begin
          rd_address <= idx;
          wait_cnt   <= '0;
          state      <= S_WAIT;
        end
        S_WAIT: begin
          // rd_address is itself registered, so capture one cycle after the latency has elapsed
          if (wait_cnt == LAT) begin
            cur_x    <= rd_data[31:23];
            cur_y    <= rd_data[18:11];
            cur_type <= rd_data[3:2];
            cur_vis  <= rd_data[1];
            state    <= S_DECODE;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        S_DECODE: begin
          dx <= '0;
          dy <= '0;
          if (need_erase)     state <= S_ERASE;
          else if (need_draw) state <= S_DRAW;
          else                state <= S_NEXT;
        end
        S_ERASE, S_DRAW: begin
          plot   <= in_range;
          plot_x <= sum_x[8:0];
          plot_y <= sum_y[7:0];
          colour <= pix_colour;
          if (dx == LAST) begin
            dx <= '0;
            dy <= (dy == LAST) ? '0 : dy + 1'b1;
          end else begin
            dx <= dx + 1'b1;
          end
          if (box_last)
            state <= (erasing && need_draw) ? S_DRAW : S_NEXT;
        end
        S_NEXT: begin
          sh_x[idx]   <= cur_x;
          sh_y[idx]   <= cur_y;
          sh_vis[idx] <= cur_vis;
          if (idx == q_lat - 4'd1) begin
            state <= S_DONE;
          end else begin
            idx   <= idx + 4'd1;
            state <= S_ADDR;
          end
        end
        S_DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stone_renderer.sv
// Self-checking bench for stone_renderer: a pixel-list model of each scan is compared
// against the plot stream, with directed cases plus randomized table updates.
module tb_stone_renderer;

  localparam int READ_LATENCY = 2;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
  } pix_t;

  logic        clock;
  logic        reset;
  logic        start;
  logic        full_redraw;
  logic [3:0]  quantity;
  logic [3:0]  rd_address;
  logic [31:0] rd_data;
  logic [8:0]  plot_x;
  logic [7:0]  plot_y;
  logic [2:0]  colour;
  logic        plot;
  logic        busy;
  logic        done;

  logic [31:0] table_mem [16];
  logic [31:0] pipe      [READ_LATENCY];

  logic [8:0]  m_sx [16];
  logic [7:0]  m_sy [16];
  bit          m_sv [16];
  pix_t        exp_q[$];

  int   checks;
  int   failures;
  int   plots_seen;
  int   done_seen;
  pix_t first_px;
  pix_t last_px;
  bit   first_pending;
  pix_t e;
  int   nplots;
  int   p0;

  stone_renderer #(.READ_LATENCY(READ_LATENCY)) dut (
    .clock(clock), .reset(reset), .start(start), .full_redraw(full_redraw),
    .quantity(quantity), .rd_address(rd_address), .rd_data(rd_data),
    .plot_x(plot_x), .plot_y(plot_y), .colour(colour), .plot(plot),
    .busy(busy), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Table read port with READ_LATENCY registered stages after the address.
  always @(posedge clock) begin
    pipe[0] <= table_mem[rd_address];
    for (int i = 1; i < READ_LATENCY; i++) pipe[i] <= pipe[i-1];
  end
  assign rd_data = pipe[READ_LATENCY-1];

  always @(negedge clock) begin
    if (!reset && plot) begin
      plots_seen++;
      if (first_pending) begin
        first_px      = {plot_x, plot_y, colour};
        first_pending = 1'b0;
      end
      last_px = {plot_x, plot_y, colour};
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_plot actual x=%0d y=%0d c=%0d required no plot",
                 plot_x, plot_y, colour);
      end else begin
        e = exp_q.pop_front();
        if ({plot_x, plot_y, colour} != e) begin
          failures++;
          $display("[TB] FAIL pixel actual x=%0d y=%0d c=%0d required x=%0d y=%0d c=%0d",
                   plot_x, plot_y, colour, e.x, e.y, e.c);
        end
      end
    end
    if (!reset && done) done_seen++;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] mk(int x, int y, int t, bit v);
    return {9'(x), 4'b0, 8'(y), 7'b0, 2'(t), v, 1'b0};
  endfunction

  function automatic logic [2:0] type_colour(logic [1:0] t);
    if (t == 2'b00) return 3'b111;
    if (t == 2'b01) return 3'b110;
    return 3'b011;
  endfunction

  function automatic void push_box(int bx, int by, logic [2:0] c);
    pix_t p;
    for (int r = 0; r < 16; r++)
      for (int k = 0; k < 16; k++)
        if (bx + k < 320 && by + r < 240) begin
          p.x = 9'(bx + k);
          p.y = 8'(by + r);
          p.c = c;
          exp_q.push_back(p);
        end
  endfunction

  // Expected pixel list of one scan, straight from the erase/draw rules.
  function automatic void model_scan(int q, bit fr);
    logic [31:0] w;
    int cx, cy;
    bit cv, mv;
    for (int i = 0; i < q; i++) begin
      w  = table_mem[i];
      cx = int'(w[31:23]);
      cy = int'(w[18:11]);
      cv = w[1];
      mv = (cx != int'(m_sx[i])) || (cy != int'(m_sy[i]));
      if (m_sv[i] && (!cv || mv)) push_box(int'(m_sx[i]), int'(m_sy[i]), 3'b000);
      if (cv && (fr || !m_sv[i] || mv)) push_box(cx, cy, type_colour(w[3:2]));
      m_sx[i] = 9'(cx);
      m_sy[i] = 8'(cy);
      m_sv[i] = cv;
    end
  endfunction

  function automatic void clear_model();
    for (int i = 0; i < 16; i++) begin
      m_sx[i] = '0;
      m_sy[i] = '0;
      m_sv[i] = 1'b0;
    end
  endfunction

  task automatic applyStimulus(input int q, input bit fr, input bit pester, input int lit,
                               output int n);
    int pstart, d0, n_exp;
    bit got;
    pstart = plots_seen;
    d0     = done_seen;
    got    = 1'b0;
    model_scan(q, fr);
    n_exp = exp_q.size();
    if (lit >= 0) checkOutput("model_count", n_exp, lit);
    quantity      = 4'(q);
    full_redraw   = fr;
    first_pending = 1'b1;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      start = pester && (i % 97 == 50);
      @(negedge clock);
    end
    start = 1'b0;
    checkOutput("done_reached", int'(got), 1);
    if (pester && got) begin
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("start_on_done_dropped", int'(busy), 0);
    end
    repeat (3) @(negedge clock);
    checkOutput("plot_count", plots_seen - pstart, n_exp);
    checkOutput("queue_drained", exp_q.size(), 0);
    checkOutput("done_pulses", done_seen - d0, 1);
    checkOutput("idle_after_done", int'(busy), 0);
    n = plots_seen - pstart;
    exp_q.delete();
  endtask

  initial begin
    checks = 0; failures = 0; plots_seen = 0; done_seen = 0;
    first_pending = 1'b0;
    reset = 1'b1; start = 1'b0; full_redraw = 1'b0; quantity = '0;
    for (int i = 0; i < 16; i++) table_mem[i] = '0;
    clear_model();

    repeat (3) @(negedge clock);
    checkOutput("reset_plot", int'(plot), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    checkOutput("reset_rd_address", int'(rd_address), 0);
    reset = 1'b0;
    @(negedge clock);

    // Empty scan: done two cycles after start, no pixels.
    p0 = plots_seen;
    quantity = 4'd0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("q0_busy", int'(busy), 1);
    checkOutput("q0_done_early", int'(done), 0);
    @(negedge clock);
    checkOutput("q0_done", int'(done), 1);
    @(negedge clock);
    checkOutput("q0_done_pulse", int'(done), 0);
    checkOutput("q0_plots", plots_seen - p0, 0);
    repeat (2) @(negedge clock);

    table_mem[0] = mk(100, 50, 1, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 256, nplots);
    checkOutput("draw_plots", nplots, 256);
    checkOutput("draw_first", int'(first_px), int'({9'd100, 8'd50, 3'b110}));
    checkOutput("draw_last", int'(last_px), int'({9'd115, 8'd65, 3'b110}));
    checkOutput("draw_rd_address", int'(rd_address), 0);

    table_mem[0] = mk(104, 50, 1, 1'b1);
    applyStimulus(1, 1'b0, 1'b0, 512, nplots);
    checkOutput("move_plots", nplots, 512);
    checkOutput("move_first", int'(first_px), int'({9'd100, 8'd50, 3'b000}));
    checkOutput("move_last", int'(last_px), int'({9'd119, 8'd65, 3'b110}));

    table_mem[0] = mk(104, 50, 1, 1'b0);
    applyStimulus(1, 1'b0, 1'b0, 256, nplots);
    checkOutput("vanish_first", int'(first_px), int'({9'd104, 8'd50, 3'b000}));
    applyStimulus(1, 1'b0, 1'b0, 0, nplots);
    checkOutput("idle_plots", nplots, 0);

    table_mem[1] = mk(310, 230, 2, 1'b1);
    applyStimulus(2, 1'b0, 1'b0, 100, nplots);
    checkOutput("clip_first", int'(first_px), int'({9'd310, 8'd230, 3'b011}));
    checkOutput("clip_last", int'(last_px), int'({9'd319, 8'd239, 3'b011}));
    checkOutput("clip_rd_address", int'(rd_address), 1);

    applyStimulus(2, 1'b1, 1'b1, 100, nplots);

    // Reset in the middle of a draw, then redraw from a cleared shadow.
    table_mem[0] = mk(20, 20, 0, 1'b1);
    model_scan(2, 1'b0);
    p0 = plots_seen;
    quantity = 4'd2;
    full_redraw = 1'b0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 2000 && plots_seen < p0 + 20; i++) @(negedge clock);
    checkOutput("mid_draw_reached", int'(plots_seen >= p0 + 20), 1);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("reset_mid_plot", int'(plot), 0);
    checkOutput("reset_mid_busy", int'(busy), 0);
    @(negedge clock);
    reset = 1'b0;
    exp_q.delete();
    clear_model();
    @(negedge clock);
    applyStimulus(2, 1'b0, 1'b0, 356, nplots);

    for (int s = 0; s < 6; s++) begin
      for (int j = 0; j < 3; j++) begin
        int k, x, y;
        k = $urandom_range(0, 7);
        x = ($urandom_range(0, 1) == 1) ? $urandom_range(280, 340) : $urandom_range(0, 511);
        y = ($urandom_range(0, 1) == 1) ? $urandom_range(200, 255) : $urandom_range(0, 255);
        table_mem[k] = mk(x, y, $urandom_range(0, 3), 1'(($urandom_range(0, 3) != 0)))
                       | ($urandom() & 32'h0078_07F1);
      end
      applyStimulus($urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    -1, nplots);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
